// File: rtl/dram_burst_model.sv
`default_nettype none
// ============================================================================
// Module   : dram_burst_model
// Brief    : Cycle-level open-page DRAM model with PRE/ACT/CAS timing,
//            BURST_LEN-beat read/write bursts and row hit/miss counters.
// Revision : 1.0 - initial release
// ============================================================================
module dram_burst_model #(
    parameter int ADDRESS_LEN        = 32,
    parameter int BURST_ACCESS_WIDTH = 32,
    parameter int BURST_LEN          = 4,
    parameter int DEPTH              = 4096,
    parameter int ROW_WORDS          = 16,
    parameter int T_RP               = 2,
    parameter int T_RCD              = 3,
    parameter int T_CL               = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDRESS_LEN-1:0]        addr,
    input  logic                          read_en,
    input  logic                          write_en,
    input  logic [BURST_ACCESS_WIDTH-1:0] wdata,
    output logic                          dram_ready,
    output logic                          dram_complete,
    output logic [BURST_ACCESS_WIDTH-1:0] rdata,
    output logic                          valid,
    output logic [31:0]                   row_hits,
    output logic [31:0]                   row_misses
);

    localparam int c_IDX_W  = $clog2(DEPTH);
    localparam int c_COL_W  = $clog2(ROW_WORDS);
    localparam int c_ROW_W  = ADDRESS_LEN - c_COL_W;
    localparam int c_BEAT_W = $clog2(BURST_LEN + 1);
    localparam int c_CNT_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ACT   = 3'd2,
        S_CAS   = 3'd3,
        S_BURST = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                         r_state;
    state_t                         w_next;
    logic [c_CNT_W-1:0]             r_cnt;
    logic [c_BEAT_W-1:0]            r_beat;
    logic [c_IDX_W-1:0]             r_base;
    logic                           r_is_read;
    logic [c_ROW_W-1:0]             r_req_row;
    logic                           r_row_open;
    logic [c_ROW_W-1:0]             r_open_row;
    logic [31:0]                    r_hits;
    logic [31:0]                    r_misses;
    logic [BURST_ACCESS_WIDTH-1:0]  r_mem [DEPTH];

    logic                           w_req;
    logic [c_ROW_W-1:0]             w_req_row;
    logic                           w_hit;
    logic [c_BEAT_W-1:0]            w_beat_m1;
    logic [c_IDX_W-1:0]             w_rd_idx;
    logic [c_IDX_W-1:0]             w_wr_idx;
    logic                           w_mem_we;

    assign w_req     = read_en | write_en;
    assign w_req_row = addr[ADDRESS_LEN-1:c_COL_W];
    assign w_hit     = r_row_open && (r_open_row == w_req_row);
    assign w_beat_m1 = r_beat - c_BEAT_W'(1);
    assign w_rd_idx  = r_base + c_IDX_W'(r_beat);
    assign w_wr_idx  = r_base + c_IDX_W'(w_beat_m1);

    // Upstream data lags valid by one cycle, so beat k lands one cycle late;
    // the final beat is therefore committed during DONE.
    assign w_mem_we  = !r_is_read &&
                       (((r_state == S_BURST) && (r_beat != '0)) || (r_state == S_DONE));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_hit)           w_next = S_CAS;
                    else if (r_row_open) w_next = S_PRE;
                    else                 w_next = S_ACT;
                end
            end
            S_PRE:   if (r_cnt == c_CNT_W'(T_RP - 1))  w_next = S_ACT;
            S_ACT:   if (r_cnt == c_CNT_W'(T_RCD - 1)) w_next = S_CAS;
            S_CAS:   if (r_cnt == c_CNT_W'(T_CL - 1))  w_next = S_BURST;
            S_BURST: if (r_beat == c_BEAT_W'(BURST_LEN - 1)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_beat     <= '0;
            r_base     <= '0;
            r_is_read  <= 1'b0;
            r_req_row  <= '0;
            r_row_open <= 1'b0;
            r_open_row <= '0;
            r_hits     <= '0;
            r_misses   <= '0;
        end else begin
            r_cnt <= (w_next != r_state) ? '0 : r_cnt + c_CNT_W'(1);
            if (r_state == S_IDLE && w_req) begin
                r_base    <= addr[c_IDX_W-1:0];
                r_is_read <= read_en;
                r_req_row <= w_req_row;
                r_beat    <= '0;
                if (w_hit) r_hits   <= r_hits + 32'd1;
                else       r_misses <= r_misses + 32'd1;
            end
            if (r_state == S_ACT && w_next == S_CAS) begin
                r_row_open <= 1'b1;
                r_open_row <= r_req_row;
            end
            if (r_state == S_BURST) r_beat <= r_beat + c_BEAT_W'(1);
        end
    end

    // Storage is deliberately not reset; only in-flight beats are dropped.
    always_ff @(posedge clk) begin
        if (!rst && w_mem_we) r_mem[w_wr_idx] <= wdata;
    end

    assign dram_ready    = !rst && (r_state == S_IDLE);
    assign valid         = !rst && (r_state == S_BURST);
    assign dram_complete = !rst && (r_state == S_DONE);
    assign rdata         = (valid && r_is_read) ? r_mem[w_rd_idx] : '0;
    assign row_hits      = r_hits;
    assign row_misses    = r_misses;

endmodule
`default_nettype wire

// File: tb/tb_dram_burst_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_burst_model
// Brief    : Directed self-checking bench for dram_burst_model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dram_burst_model;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic        read_en = 1'b0;
    logic        write_en = 1'b0;
    logic [31:0] wdata = '0;
    logic        dram_ready;
    logic        dram_complete;
    logic [31:0] rdata;
    logic        valid;
    logic [31:0] row_hits;
    logic [31:0] row_misses;

    int n_checks = 0;
    int n_pass   = 0;

    int          r_first;
    int          r_comp;
    int          r_nvalid;
    logic [31:0] r_rd [4];

    dram_burst_model dut (
        .clk           (clk),
        .rst           (rst),
        .addr          (addr),
        .read_en       (read_en),
        .write_en      (write_en),
        .wdata         (wdata),
        .dram_ready    (dram_ready),
        .dram_complete (dram_complete),
        .rdata         (rdata),
        .valid         (valid),
        .row_hits      (row_hits),
        .row_misses    (row_misses)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Called just after a rising edge; that cycle is cycle 0 (accept).
    // Write beats follow the upstream rule: wbase+k appears after the edge
    // ending valid beat k. abort_at>0 asserts rst in the cycle of valid
    // beat number abort_at+1 and returns.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wbase, input logic hold, input int abort_at);
        int  wbeat;
        bit  pend;
        read_en  = rd;
        write_en = wr;
        addr     = a;
        r_first  = -1;
        r_comp   = -1;
        r_nvalid = 0;
        wbeat    = 0;
        for (int k = 0; k < 4; k++) r_rd[k] = 'x;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) check("ready_at_accept", 32'(dram_ready), 32'd1);
            if (valid) begin
                if (r_first < 0) r_first = c;
                if (r_nvalid < 4) r_rd[r_nvalid] = rdata;
                r_nvalid++;
            end
            if (dram_complete && r_comp < 0) r_comp = c;
            pend = valid && wr && !rd;
            @(posedge clk);
            #1;
            if (c == 0 && !hold) begin
                read_en  = 1'b0;
                write_en = 1'b0;
                addr     = 32'hDEAD_BEEF;
            end
            if (pend) begin
                wdata = wbase + 32'(wbeat);
                wbeat++;
            end else begin
                wdata = 32'h5555_5555;
            end
            if (abort_at > 0 && r_nvalid == abort_at) begin
                rst      = 1'b1;
                read_en  = 1'b0;
                write_en = 1'b0;
                return;
            end
            if (r_comp >= 0) begin
                read_en  = 1'b0;
                write_en = 1'b0;
                return;
            end
        end
        check("request_timeout", 32'(r_comp), 32'd0);
    endtask

    initial begin
        // Reset for 3 cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(dram_ready), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_complete", 32'(dram_complete), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_hits", row_hits, 32'd0);
        check("rst_misses", row_misses, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("idle_ready", 32'(dram_ready), 32'd1);
            check("idle_valid", 32'(valid), 32'd0);
            check("idle_complete", 32'(dram_complete), 32'd0);
        end
        @(posedge clk);
        #1;

        // Closed-row write 0x10
        do_req(1'b1 ^ 1'b1, 1'b1, 32'h10, 32'hA1, 1'b0, 0);
        check("wr_first_valid", 32'(r_first), 32'd8);
        check("wr_complete", 32'(r_comp), 32'd12);
        check("wr_nvalid", 32'(r_nvalid), 32'd4);
        check("wr_misses", row_misses, 32'd1);
        check("wr_hits", row_hits, 32'd0);

        // Row-hit read 0x10
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 0);
        check("hit_first_valid", 32'(r_first), 32'd5);
        check("hit_complete", 32'(r_comp), 32'd9);
        for (int k = 0; k < 4; k++) check("hit_rdata", r_rd[k], 32'hA1 + 32'(k));
        check("hit_hits", row_hits, 32'd1);

        // Row conflict read 0x20
        do_req(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 0);
        check("conf_first_valid", 32'(r_first), 32'd10);
        check("conf_complete", 32'(r_comp), 32'd14);
        check("conf_misses", row_misses, 32'd2);
        do_req(1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 0);
        check("row2_open_first", 32'(r_first), 32'd5);
        check("row2_open_hits", row_hits, 32'd2);

        // Simultaneous read+write: read wins, held through DONE
        do_req(1'b1, 1'b1, 32'h10, 32'hFF, 1'b1, 0);
        check("both_first_valid", 32'(r_first), 32'd10);
        for (int k = 0; k < 4; k++) check("both_rdata", r_rd[k], 32'hA1 + 32'(k));
        check("both_misses", row_misses, 32'd3);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("no_reaccept_ready", 32'(dram_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 0);
        check("both_after_first", 32'(r_first), 32'd5);
        check("both_after_rdata", r_rd[0], 32'hA1);
        check("both_after_hits", row_hits, 32'd3);

        // Reset during the 2nd read valid cycle
        do_req(1'b1, 1'b0, 32'h11, 32'h0, 1'b0, 1);
        check("abort_first_rdata", r_rd[0], 32'hA2);
        @(negedge clk);
        check("abort_rst_valid", 32'(valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_ready", 32'(dram_ready), 32'd1);
        check("abort_hits", row_hits, 32'd0);
        check("abort_misses", row_misses, 32'd0);
        @(posedge clk);
        #1;
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 0);
        check("post_rst_first", 32'(r_first), 32'd8);
        for (int k = 0; k < 4; k++) check("post_rst_rdata", r_rd[k], 32'hA1 + 32'(k));
        check("post_rst_misses", row_misses, 32'd1);

        // Write crossing a row boundary is timed as its base row
        do_req(1'b0, 1'b1, 32'h1E, 32'hB0, 1'b0, 0);
        check("cross_wr_first", 32'(r_first), 32'd5);
        check("cross_wr_complete", 32'(r_comp), 32'd9);
        check("cross_wr_hits", row_hits, 32'd1);
        do_req(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 0);
        check("cross_rd_first", 32'(r_first), 32'd10);
        check("cross_rd_beat0", r_rd[0], 32'hB2);
        check("cross_rd_beat1", r_rd[1], 32'hB3);
        check("cross_rd_misses", row_misses, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
